// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: two-stage RGB to level-shifted signed JPEG Y/Cb/Cr converter.
module rgb_to_ycbcr #(
    parameter int OUT_W = 10,
    parameter int FRAC  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    output logic               out_valid,
    output logic [3*OUT_W-1:0] out
);
    localparam logic signed [17:0] HALF = 18'sd1 <<< (FRAC - 1);
    logic signed [17:0] rs, gs, bs, sy, scb, scr;
    logic               v1;
    assign rs = $signed({10'd0, r});
    assign gs = $signed({10'd0, g});
    assign bs = $signed({10'd0, b});
    // Round-half-up via floor shift, apply offset, then saturate to a signed byte.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [17:0] s, input logic signed [17:0] off);
        logic signed [17:0] v, c;
        v = ((s + HALF) >>> FRAC) - off;
        c = v > 18'sd127 ? 18'sd127 : v < -18'sd128 ? -18'sd128 : v;
        return OUT_W'(c);
    endfunction
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            sy        <= '0;
            scb       <= '0;
            scr       <= '0;
            v1        <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            sy        <= 18'sd77 * rs + 18'sd150 * gs + 18'sd29 * bs;
            scb       <= -18'sd43 * rs - 18'sd85 * gs + 18'sd128 * bs;
            scr       <= 18'sd128 * rs - 18'sd107 * gs - 18'sd21 * bs;
            v1        <= in_valid;
            out       <= {sat(sy, 18'sd128), sat(scb, 18'sd0), sat(scr, 18'sd0)};
            out_valid <= v1;
        end
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: directed and random checks of the RGB to YCbCr pipeline.
module tb_rgb_to_ycbcr;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        out_valid;
    logic [29:0] out;
    int          total = 0, passed = 0;
    logic        pv [2];
    logic [29:0] pe [2];
    string       pt [2];

    rgb_to_ycbcr dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .out(out)
    );

    always #5 clock = ~clock;

    function automatic logic [29:0] pk(input int y, input int cb, input int cr);
        return {10'(y), 10'(cb), 10'(cr)};
    endfunction

    // Independent floor-division reference for the rounded, clamped field.
    function automatic logic [9:0] fld(input int s, input int off);
        int t, v;
        t = s + 128;
        v = (t >= 0) ? t / 256 : -((-t + 255) / 256);
        v = v - off;
        v = (v > 127) ? 127 : (v < -128) ? -128 : v;
        return 10'(v);
    endfunction

    function automatic logic [29:0] model(input int rr, input int gg, input int bb);
        return {fld(77*rr + 150*gg + 29*bb, 128), fld(-43*rr - 85*gg + 128*bb, 0),
                fld(128*rr - 107*gg - 21*bb, 0)};
    endfunction

    function automatic logic in_range(input logic [29:0] o);
        logic [8:0] hi;
        hi = {o[29:27], o[19:17], o[9:7]};
        return (hi[8:6] == 3'b000 || hi[8:6] == 3'b111) && (hi[5:3] == 3'b000 || hi[5:3] == 3'b111)
            && (hi[2:0] == 3'b000 || hi[2:0] == 3'b111);
    endfunction

    task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_pipe();
        pv[0] = 1'b0; pv[1] = 1'b0;
        pe[0] = '0;   pe[1] = '0;
        pt[0] = "";   pt[1] = "";
    endtask

    // At each falling edge: check the result due from two pixels ago, then drive the next pixel.
    task automatic push(input string tag, input logic iv, input logic [7:0] rr, input logic [7:0] gg,
                        input logic [7:0] bb, input logic [29:0] e);
        @(negedge clock);
        chk({pt[1], "_valid"}, {29'b0, out_valid}, {29'b0, pv[1]});
        if (pv[1]) chk(pt[1], out, pe[1]);
        pv[1] = pv[0]; pe[1] = pe[0]; pt[1] = pt[0];
        pv[0] = iv;    pe[0] = e;     pt[0] = tag;
        in_valid = iv; r = rr; g = gg; b = bb;
    endtask

    initial begin
        logic [7:0] rr, gg, bb;
        clear_pipe();
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        #1 chk("reset_out", out, '0);
        chk("reset_valid", {29'b0, out_valid}, '0);
        repeat (3) begin
            @(negedge clock);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
        end
        @(negedge clock);
        chk("reset_hold_out", out, '0);
        chk("reset_hold_valid", {29'b0, out_valid}, '0);
        in_valid = 1'b0;
        reset_n  = 1'b1;

        push("black", 1, 8'd0,   8'd0,   8'd0,   {10'h380, 10'h000, 10'h000});
        push("white", 1, 8'd255, 8'd255, 8'd255, pk(127, 0, 0));
        push("grey",  1, 8'd128, 8'd128, 8'd128, pk(0, 0, 0));
        push("red",   1, 8'd255, 8'd0,   8'd0,   pk(-51, -43, 127));
        push("green", 1, 8'd0,   8'd255, 8'd0,   pk(21, -85, -107));
        push("blue",  1, 8'd0,   8'd0,   8'd255, pk(-99, 127, -21));
        push("gap",   0, 8'd200, 8'd10,  8'd90,  '0);
        push("red2",  1, 8'd255, 8'd0,   8'd0,   pk(-51, -43, 127));
        push("blue2", 1, 8'd0,   8'd0,   8'd255, pk(-99, 127, -21));
        push("idle",  0, 8'd0,   8'd0,   8'd0,   '0);
        push("idle",  0, 8'd0,   8'd0,   8'd0,   '0);
        push("idle",  0, 8'd0,   8'd0,   8'd0,   '0);

        push("inflight1", 1, 8'd255, 8'd255, 8'd255, pk(127, 0, 0));
        push("inflight2", 1, 8'd0,   8'd255, 8'd0,   pk(21, -85, -107));
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk("midreset_out", out, '0);
        chk("midreset_valid", {29'b0, out_valid}, '0);
        in_valid = 1'b0;
        clear_pipe();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) push("post_reset", 0, 8'd0, 8'd0, 8'd0, '0);

        for (int i = 0; i < 2000; i++) begin
            rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
            push("sweep", 1, rr, gg, bb, model(rr, gg, bb));
            if (out_valid) chk("sweep_range", {29'b0, in_range(out)}, 30'd1);
        end
        repeat (2) push("flush", 0, 8'd0, 8'd0, 8'd0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
